mu0_sequencer: RTL

//   Parametrised MU0 control unit: owns the FETCH/EXEC1/EXEC2/HALT state register, a skip-next flag
//   and a multi-cycle shift counter, and drives all datapath controls. Sits between the IR and the
//   PC/ACC/memory datapath; replaces the free-standing phase generator plus combinational decoder.
//   New: sticky HALT on STP, conditional skip (SKC), and N-bit shifts (LSR/ASR by 1..2^SHIFT_CNT_W-1).

---
 rtl/mu0_pkg.sv | 56 +++++
 rtl/mu0_opdecode.sv | 34 +++
 rtl/mu0_sequencer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 control unit: opcodes, ARM-ish sub-ops,
// state encoding and indices into the one-hot decoded-opcode vector.
package mu0_pkg;

  localparam logic [3:0] OPC_LDA = 4'h0;
  localparam logic [3:0] OPC_STA = 4'h1;
  localparam logic [3:0] OPC_ADD = 4'h2;
  localparam logic [3:0] OPC_SUB = 4'h3;
  localparam logic [3:0] OPC_JMP = 4'h4;
  localparam logic [3:0] OPC_JMI = 4'h5;
  localparam logic [3:0] OPC_JEQ = 4'h6;
  localparam logic [3:0] OPC_STP = 4'h7;
  localparam logic [3:0] OPC_LDI = 4'h8;
  localparam logic [3:0] OPC_SKC = 4'h9;
  localparam logic [3:0] OPC_LSR = 4'hA;
  localparam logic [3:0] OPC_ASR = 4'hB;

  localparam logic [2:0] ARM_ADD = 3'b000;
  localparam logic [2:0] ARM_SUB = 3'b001;
  localparam logic [2:0] ARM_MOV = 3'b010;
  localparam logic [2:0] ARM_XSR = 3'b011;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC1 = 2'd1;
  localparam logic [1:0] ST_EXEC2 = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  // Indices 0..11 match the opcode value so the decoder can generate them.
  localparam int OP_LDA     = 0;
  localparam int OP_STA     = 1;
  localparam int OP_ADD     = 2;
  localparam int OP_SUB     = 3;
  localparam int OP_JMP     = 4;
  localparam int OP_JMI     = 5;
  localparam int OP_JEQ     = 6;
  localparam int OP_STP     = 7;
  localparam int OP_LDI     = 8;
  localparam int OP_SKC     = 9;
  localparam int OP_LSR     = 10;
  localparam int OP_ASR     = 11;
  localparam int OP_ARM_ADD = 12;
  localparam int OP_ARM_SUB = 13;
  localparam int OP_ARM_MOV = 14;
  localparam int OP_ARM_XSR = 15;
  localparam int OP_UNDEF   = 16;
  localparam int NUM_OPS    = 17;

  function automatic logic is_two_cycle(input logic [NUM_OPS-1:0] ops);
    return ops[OP_LDA] | ops[OP_ADD] | ops[OP_SUB];
  endfunction

  function automatic logic is_shift(input logic [NUM_OPS-1:0] ops);
    return ops[OP_LSR] | ops[OP_ASR];
  endfunction

endpackage

// File: rtl/mu0_opdecode.sv
// Combinational instruction decoder: IR -> one-hot opcode vector, including
// the ARM-ish sub-op space (opcodes C-F, sub-op in IR[6:4]).
module mu0_opdecode
  import mu0_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0]  ir,
  output logic [NUM_OPS-1:0] ops
);

  logic [3:0] opcode;
  logic [2:0] arm_sub;
  logic       arm_space;
  logic       unused_ir;

  assign opcode    = ir[DATA_W-1 -: 4];
  assign arm_sub   = ir[6:4];
  assign arm_space = opcode[3] & opcode[2];
  assign unused_ir = ^{ir[DATA_W-5:7], ir[3:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 12; gi++) begin : g_base
      assign ops[gi] = (opcode == 4'(gi));
    end
    for (gi = 0; gi < 4; gi++) begin : g_arm
      assign ops[OP_ARM_ADD + gi] = arm_space & (arm_sub == 3'(gi));
    end
  endgenerate

  assign ops[OP_UNDEF] = arm_space & arm_sub[2];

endmodule

// File: rtl/mu0_sequencer.sv
// MU0 control unit: phase state register, skip-next flag and multi-cycle
// shift counter, with all datapath controls decoded combinationally.
module mu0_sequencer
  import mu0_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SHIFT_CNT_W = 4,
  parameter int HALT_ON_STP = 1
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IR,
  input  logic              EQ,
  input  logic              MI,
  output logic              FETCH,
  output logic              EXEC1,
  output logic              EXEC2,
  output logic              HALTED,
  output logic              IR_EN,
  output logic              EXTRA,
  output logic              Wren,
  output logic              MUX1,
  output logic              MUX3,
  output logic              MUX3_useAllBits,
  output logic              PC_sload,
  output logic              PC_cnt_en,
  output logic              ACC_EN,
  output logic              ACC_LOAD,
  output logic              ACC_SHIFTIN,
  output logic              ADDSUB,
  output logic              SKIP_PEND,
  output logic              SHIFT_BUSY
);

  logic [1:0]             state_reg, state_next;
  logic                   skip_reg, skip_next;
  logic [SHIFT_CNT_W-1:0] cnt_reg, cnt_next;

  logic [NUM_OPS-1:0]     ops;
  logic [SHIFT_CNT_W-1:0] shift_field;
  logic [SHIFT_CNT_W-1:0] shift_n;
  logic [SHIFT_CNT_W:0]   cnt_plus1;
  logic                   shift_last;
  logic                   two_cycle;
  logic                   shifting;
  logic                   nop_like;
  logic                   skc_hit;
  logic                   halt_on_stp;

  mu0_opdecode #(.DATA_W(DATA_W)) u_opdecode (
    .ir  (IR),
    .ops (ops)
  );

  assign shift_field = IR[SHIFT_CNT_W-1:0];
  assign shift_n     = (shift_field == '0) ? SHIFT_CNT_W'(1) : shift_field;
  assign cnt_plus1   = {1'b0, cnt_reg} + (SHIFT_CNT_W+1)'(1);
  // Last shift cycle once this cycle completes the n-th step.
  assign shift_last  = (cnt_plus1 >= {1'b0, shift_n});
  assign two_cycle   = is_two_cycle(ops);
  assign shifting    = is_shift(ops);
  assign nop_like    = |ops[OP_UNDEF:OP_ARM_ADD];
  assign skc_hit     = (IR[0] & EQ) | (IR[1] & MI);
  assign halt_on_stp = (HALT_ON_STP != 0);

  always_comb begin
    state_next = state_reg;
    skip_next  = skip_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_FETCH: begin
        state_next = ST_EXEC1;
        cnt_next   = '0;
      end
      ST_EXEC1: begin
        cnt_next   = cnt_plus1[SHIFT_CNT_W-1:0];
        state_next = ST_FETCH;
        if (skip_reg) begin
          skip_next = 1'b0;
        end else if (two_cycle) begin
          state_next = ST_EXEC2;
        end else if (shifting && !shift_last) begin
          state_next = ST_EXEC1;
        end else if (ops[OP_STP] && halt_on_stp) begin
          state_next = ST_HALT;
        end else if (ops[OP_SKC] && skc_hit) begin
          skip_next = 1'b1;
        end
      end
      ST_EXEC2: state_next = ST_FETCH;
      default:  state_next = ST_HALT;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg <= ST_FETCH;
      skip_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      skip_reg  <= skip_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    FETCH           = 1'b0;
    EXEC1           = 1'b0;
    EXEC2           = 1'b0;
    HALTED          = 1'b0;
    IR_EN           = 1'b0;
    EXTRA           = 1'b0;
    Wren            = 1'b0;
    MUX1            = 1'b0;
    MUX3            = 1'b0;
    MUX3_useAllBits = 1'b0;
    PC_sload        = 1'b0;
    PC_cnt_en       = 1'b0;
    ACC_EN          = 1'b0;
    ACC_LOAD        = 1'b0;
    ACC_SHIFTIN     = 1'b0;
    ADDSUB          = 1'b0;
    SHIFT_BUSY      = 1'b0;
    SKIP_PEND       = skip_reg;
    case (state_reg)
      ST_FETCH: begin
        FETCH = 1'b1;
        IR_EN = 1'b1;
      end
      ST_EXEC1: begin
        EXEC1 = 1'b1;
        // A skipped instruction only advances the PC.
        if (skip_reg) begin
          PC_cnt_en = 1'b1;
        end else if (two_cycle) begin
          MUX1  = 1'b1;
          EXTRA = 1'b1;
        end else if (ops[OP_STA]) begin
          MUX1      = 1'b1;
          Wren      = 1'b1;
          PC_cnt_en = 1'b1;
        end else if (ops[OP_LDI]) begin
          MUX3      = 1'b1;
          ACC_EN    = 1'b1;
          ACC_LOAD  = 1'b1;
          PC_cnt_en = 1'b1;
        end else if (ops[OP_JMP]) begin
          PC_sload = 1'b1;
        end else if (ops[OP_JMI]) begin
          PC_sload  = MI;
          PC_cnt_en = !MI;
        end else if (ops[OP_JEQ]) begin
          PC_sload  = EQ;
          PC_cnt_en = !EQ;
        end else if (ops[OP_STP]) begin
          PC_cnt_en = !halt_on_stp;
        end else if (shifting) begin
          ACC_EN          = 1'b1;
          MUX3_useAllBits = 1'b1;
          ACC_SHIFTIN     = ops[OP_ASR] & MI;
          PC_cnt_en       = shift_last;
          SHIFT_BUSY      = !shift_last;
        end else if (ops[OP_SKC] || nop_like) begin
          PC_cnt_en = 1'b1;
        end
      end
      ST_EXEC2: begin
        EXEC2           = 1'b1;
        ACC_EN          = 1'b1;
        ACC_LOAD        = 1'b1;
        PC_cnt_en       = 1'b1;
        ADDSUB          = ops[OP_ADD];
        MUX3            = ops[OP_LDA];
        MUX3_useAllBits = ops[OP_LDA];
      end
      default: begin
        HALTED    = 1'b1;
        SKIP_PEND = 1'b0;
      end
    endcase
  end

endmodule
